// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges scalar and vector pipeline results onto the scalar
// and vector register-file write ports, queueing vector results that lose.
module wb_arbiter #(
   parameter int QDEPTH = 4,
   parameter int HWM    = QDEPTH - 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   input  logic         s_reg_we,
   input  logic         s_vreg_we,
   input  logic [4:0]   s_rd,
   input  logic [4:0]   s_vd,
   input  logic [35:0]  s_wb,
   input  logic [127:0] s_vwb,
   input  logic [3:0]   s_mask,
   input  logic         v_valid,
   input  logic         v_reg_we,
   input  logic         v_vreg_we,
   input  logic [4:0]   v_rd,
   input  logic [4:0]   v_vd,
   input  logic [35:0]  v_wb,
   input  logic [127:0] v_vwb,
   input  logic [3:0]   v_mask,
   output logic         s_stall,
   output logic         reg_we,
   output logic [4:0]   reg_addr,
   output logic [35:0]  reg_data,
   output logic [3:0]   vreg_we,
   output logic [4:0]   vreg_addr,
   output logic [127:0] vreg_data,
   output logic [$clog2(QDEPTH):0] q_count,
   output logic         q_overflow
);

   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] HWM_C  = CW'(HWM);
   localparam logic [CW-1:0] FULL_C = CW'(QDEPTH);

   typedef struct packed {
      logic         reg_we;
      logic         vreg_we;
      logic [4:0]   rd;
      logic [4:0]   vd;
      logic [35:0]  wb;
      logic [127:0] vwb;
      logic [3:0]   mask;
   } entry_t;

   entry_t         q_mem [QDEPTH];
   logic [AW-1:0]  head;
   logic [AW-1:0]  tail;
   entry_t         live_e;
   entry_t         cand;
   logic           q_empty;
   logic           cand_valid;
   logic           cand_r, cand_v, s_r, s_v;
   logic           conflict, vec_wins;
   logic           grant_s, grant_v;
   logic           pop, push, push_ok, drop;
   logic           r_from_s, r_from_v, v_from_s, v_from_v;

   assign live_e = {v_reg_we, v_vreg_we, v_rd, v_vd, v_wb, v_vwb, v_mask};

   // Queued results always go before live vector input so vector order holds.
   assign q_empty    = (q_count == '0);
   assign cand       = q_empty ? live_e : q_mem[head];
   assign cand_valid = q_empty ? v_valid : 1'b1;

   assign s_r    = s_valid & s_reg_we;
   assign s_v    = s_valid & s_vreg_we;
   assign cand_r = cand_valid & cand.reg_we;
   assign cand_v = cand_valid & cand.vreg_we;

   // Handshake: the scalar result is consumed on any edge where s_valid=1 and
   // s_stall=0; while s_stall=1 upstream holds the scalar inputs unchanged.
   // The vector side has no back-pressure; every v_valid result is taken.
   assign conflict = (s_r & cand_r) | (s_v & cand_v);
   assign vec_wins = conflict & (q_count >= HWM_C);
   assign s_stall  = vec_wins;

   // Grants are whole-result: a loser gets none of its ports.
   assign grant_s = s_valid & ~vec_wins;
   assign grant_v = cand_valid & ~(conflict & ~vec_wins);

   assign pop     = ~q_empty & grant_v;
   assign push    = v_valid & ~(q_empty & grant_v);
   assign drop    = push & (q_count == FULL_C) & ~pop;
   assign push_ok = push & ~drop;

   assign r_from_s = grant_s & s_r;
   assign r_from_v = grant_v & cand_r;
   assign v_from_s = grant_s & s_v;
   assign v_from_v = grant_v & cand_v;

   always_ff @(posedge clk) begin
      if (push_ok) q_mem[tail] <= live_e;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head       <= '0;
         tail       <= '0;
         q_count    <= '0;
         q_overflow <= 1'b0;
      end else begin
         if (pop)     head <= head + 1'b1;
         if (push_ok) tail <= tail + 1'b1;
         case ({push_ok, pop})
            2'b10:   q_count <= q_count + 1'b1;
            2'b01:   q_count <= q_count - 1'b1;
            default: q_count <= q_count;
         endcase
         if (drop) q_overflow <= 1'b1;
      end
   end

   // Write ports: enables pulse per grant, addr/data hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_we    <= 1'b0;
         reg_addr  <= '0;
         reg_data  <= '0;
         vreg_we   <= '0;
         vreg_addr <= '0;
         vreg_data <= '0;
      end else begin
         reg_we <= r_from_s | r_from_v;
         if (r_from_s) begin
            reg_addr <= s_rd;
            reg_data <= s_wb;
         end else if (r_from_v) begin
            reg_addr <= cand.rd;
            reg_data <= cand.wb;
         end
         if (v_from_s) begin
            vreg_we   <= s_mask;
            vreg_addr <= s_vd;
            vreg_data <= s_vwb;
         end else if (v_from_v) begin
            vreg_we   <= cand.mask;
            vreg_addr <= cand.vd;
            vreg_data <= cand.vwb;
         end else begin
            vreg_we   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, bypass, queueing, high-water stall,
// atomic retirement and mid-stream reset.
module tb_wb_arbiter;

   logic         clk;
   logic         rst;
   logic         s_valid, s_reg_we, s_vreg_we;
   logic [4:0]   s_rd, s_vd;
   logic [35:0]  s_wb;
   logic [127:0] s_vwb;
   logic [3:0]   s_mask;
   logic         v_valid, v_reg_we, v_vreg_we;
   logic [4:0]   v_rd, v_vd;
   logic [35:0]  v_wb;
   logic [127:0] v_vwb;
   logic [3:0]   v_mask;
   logic         s_stall;
   logic         reg_we;
   logic [4:0]   reg_addr;
   logic [35:0]  reg_data;
   logic [3:0]   vreg_we;
   logic [4:0]   vreg_addr;
   logic [127:0] vreg_data;
   logic [2:0]   q_count;
   logic         q_overflow;

   int checks_total;
   int checks_passed;

   wb_arbiter #(.QDEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_reg_we(s_reg_we), .s_vreg_we(s_vreg_we),
      .s_rd(s_rd), .s_vd(s_vd), .s_wb(s_wb), .s_vwb(s_vwb), .s_mask(s_mask),
      .v_valid(v_valid), .v_reg_we(v_reg_we), .v_vreg_we(v_vreg_we),
      .v_rd(v_rd), .v_vd(v_vd), .v_wb(v_wb), .v_vwb(v_vwb), .v_mask(v_mask),
      .s_stall(s_stall), .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
      .vreg_we(vreg_we), .vreg_addr(vreg_addr), .vreg_data(vreg_data),
      .q_count(q_count), .q_overflow(q_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_s(input logic vl, input logic we, input logic vwe, input logic [4:0] rd,
                        input logic [4:0] vd, input logic [35:0] wb, input logic [127:0] vwb,
                        input logic [3:0] mask);
      s_valid = vl; s_reg_we = we; s_vreg_we = vwe; s_rd = rd;
      s_vd = vd; s_wb = wb; s_vwb = vwb; s_mask = mask;
   endtask

   task automatic set_v(input logic vl, input logic we, input logic vwe, input logic [4:0] rd,
                        input logic [4:0] vd, input logic [35:0] wb, input logic [127:0] vwb,
                        input logic [3:0] mask);
      v_valid = vl; v_reg_we = we; v_vreg_we = vwe; v_rd = rd;
      v_vd = vd; v_wb = wb; v_vwb = vwb; v_mask = mask;
   endtask

   task automatic idle();
      set_s(0, 0, 0, 0, 0, 0, 0, 0);
      set_v(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      step();
      step();
      checks_total++;
      if ({reg_we, reg_addr, reg_data, vreg_we, vreg_addr, vreg_data, q_count, q_overflow, s_stall} !== '0)
         $display("FAIL reset_outputs: got reg_we=%0d vreg_we=%0d q_count=%0d ovf=%0d stall=%0d exp all 0",
                  reg_we, vreg_we, q_count, q_overflow, s_stall);
      else checks_passed++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_scalar_write();
      set_s(1, 1, 0, 5'd3, 0, 36'h123, 0, 0);
      #1;
      checks_total++;
      if (s_stall !== 1'b0) $display("FAIL scalar_stall: got %0d exp 0", s_stall); else checks_passed++;
      step();
      checks_total++;
      if ({reg_we, reg_addr, reg_data, vreg_we} !== {1'b1, 5'd3, 36'h123, 4'b0})
         $display("FAIL scalar_write: got we=%0d addr=%0d data=%h vwe=%b exp 1/3/123/0000",
                  reg_we, reg_addr, reg_data, vreg_we);
      else checks_passed++;
      idle();
      step();
      checks_total++;
      if ({reg_we, reg_addr, reg_data} !== {1'b0, 5'd3, 36'h123})
         $display("FAIL scalar_hold: got we=%0d addr=%0d data=%h exp 0/3/123", reg_we, reg_addr, reg_data);
      else checks_passed++;
   endtask

   task automatic test_disjoint();
      set_s(1, 1, 0, 5'd1, 0, 36'h11, 0, 0);
      set_v(1, 0, 1, 0, 5'd2, 0, 128'hABCD_0000_1234, 4'b1010);
      step();
      checks_total++;
      if ({reg_we, reg_addr, reg_data} !== {1'b1, 5'd1, 36'h11})
         $display("FAIL disjoint_r: got we=%0d addr=%0d data=%h exp 1/1/11", reg_we, reg_addr, reg_data);
      else checks_passed++;
      checks_total++;
      if ({vreg_we, vreg_addr, vreg_data, q_count} !== {4'b1010, 5'd2, 128'hABCD_0000_1234, 3'd0})
         $display("FAIL disjoint_v: got vwe=%b vaddr=%0d vdata=%h q=%0d exp 1010/2/abcd00001234/0",
                  vreg_we, vreg_addr, vreg_data, q_count);
      else checks_passed++;
      idle();
      step();
   endtask

   task automatic test_conflict_queue();
      set_s(1, 1, 0, 5'd5, 0, 36'h55, 0, 0);
      set_v(1, 1, 0, 5'd6, 0, 36'h66, 0, 0);
      #1;
      checks_total++;
      if (s_stall !== 1'b0) $display("FAIL conflict_stall: got %0d exp 0", s_stall); else checks_passed++;
      step();
      checks_total++;
      if ({reg_we, reg_addr, reg_data, q_count} !== {1'b1, 5'd5, 36'h55, 3'd1})
         $display("FAIL conflict_scalar: got we=%0d addr=%0d data=%h q=%0d exp 1/5/55/1",
                  reg_we, reg_addr, reg_data, q_count);
      else checks_passed++;
      idle();
      step();
      checks_total++;
      if ({reg_we, reg_addr, reg_data, q_count} !== {1'b1, 5'd6, 36'h66, 3'd0})
         $display("FAIL conflict_drain: got we=%0d addr=%0d data=%h q=%0d exp 1/6/66/0",
                  reg_we, reg_addr, reg_data, q_count);
      else checks_passed++;
   endtask

   task automatic test_sustained();
      // Fill phase: scalar wins while the queue is below the high-water mark.
      for (int i = 0; i < 3; i++) begin
         set_s(1, 1, 0, 5'(10 + i), 0, 36'(256 + i), 0, 0);
         set_v(1, 1, 0, 5'(20 + i), 0, 36'(512 + i), 0, 0);
         #1;
         checks_total++;
         if (s_stall !== 1'b0) $display("FAIL fill_stall_%0d: got %0d exp 0", i, s_stall); else checks_passed++;
         step();
         checks_total++;
         if ({reg_addr, reg_data, q_count} !== {5'(10 + i), 36'(256 + i), 3'(i + 1)})
            $display("FAIL fill_%0d: got addr=%0d data=%h q=%0d exp %0d/%h/%0d",
                     i, reg_addr, reg_data, q_count, 10 + i, 256 + i, i + 1);
         else checks_passed++;
      end
      // Stall phase: scalar held (rd 13), queue head wins, vector order kept.
      for (int j = 0; j < 3; j++) begin
         set_s(1, 1, 0, 5'd13, 0, 36'h103, 0, 0);
         set_v(1, 1, 0, 5'(23 + j), 0, 36'(512 + 3 + j), 0, 0);
         #1;
         checks_total++;
         if (s_stall !== 1'b1) $display("FAIL hwm_stall_%0d: got %0d exp 1", j, s_stall); else checks_passed++;
         step();
         checks_total++;
         if ({reg_we, reg_addr, reg_data, q_count, q_overflow} !== {1'b1, 5'(20 + j), 36'(512 + j), 3'd3, 1'b0})
            $display("FAIL hwm_pop_%0d: got we=%0d addr=%0d data=%h q=%0d ovf=%0d exp 1/%0d/%h/3/0",
                     j, reg_we, reg_addr, reg_data, q_count, q_overflow, 20 + j, 512 + j);
         else checks_passed++;
      end
      // Drain: vector idle, scalar still held.
      set_v(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks_total++;
      if (s_stall !== 1'b1) $display("FAIL drain_stall: got %0d exp 1", s_stall); else checks_passed++;
      step();
      checks_total++;
      if ({reg_addr, q_count} !== {5'd23, 3'd2})
         $display("FAIL drain_0: got addr=%0d q=%0d exp 23/2", reg_addr, q_count);
      else checks_passed++;
      #1;
      checks_total++;
      if (s_stall !== 1'b0) $display("FAIL drain_release: got %0d exp 0", s_stall); else checks_passed++;
      step();
      checks_total++;
      if ({reg_addr, reg_data, q_count} !== {5'd13, 36'h103, 3'd2})
         $display("FAIL drain_scalar: got addr=%0d data=%h q=%0d exp 13/103/2", reg_addr, reg_data, q_count);
      else checks_passed++;
      idle();
      step();
      checks_total++;
      if ({reg_addr, q_count} !== {5'd24, 3'd1})
         $display("FAIL drain_1: got addr=%0d q=%0d exp 24/1", reg_addr, q_count);
      else checks_passed++;
      step();
      checks_total++;
      if ({reg_addr, reg_data, q_count} !== {5'd25, 36'(517), 3'd0})
         $display("FAIL drain_2: got addr=%0d data=%h q=%0d exp 25/205/0", reg_addr, reg_data, q_count);
      else checks_passed++;
   endtask

   task automatic test_atomic();
      set_s(1, 1, 0, 5'd7, 0, 36'h77, 0, 0);
      set_v(1, 1, 1, 5'd8, 5'd9, 36'h88, 128'h99, 4'b1111);
      step();
      checks_total++;
      if ({reg_we, reg_addr, vreg_we, q_count} !== {1'b1, 5'd7, 4'b0, 3'd1})
         $display("FAIL atomic_split: got we=%0d addr=%0d vwe=%b q=%0d exp 1/7/0000/1",
                  reg_we, reg_addr, vreg_we, q_count);
      else checks_passed++;
      idle();
      step();
      checks_total++;
      if ({reg_we, reg_addr, reg_data, vreg_we, vreg_addr, vreg_data, q_count} !==
          {1'b1, 5'd8, 36'h88, 4'b1111, 5'd9, 128'h99, 3'd0})
         $display("FAIL atomic_retire: got we=%0d addr=%0d vwe=%b vaddr=%0d q=%0d exp 1/8/1111/9/0",
                  reg_we, reg_addr, vreg_we, vreg_addr, q_count);
      else checks_passed++;
   endtask

   task automatic test_no_write();
      set_s(1, 0, 0, 5'd30, 5'd30, 36'hFFF, 128'hFFF, 4'b1111);
      set_v(1, 0, 0, 5'd31, 5'd31, 36'hEEE, 128'hEEE, 4'b1111);
      #1;
      checks_total++;
      if (s_stall !== 1'b0) $display("FAIL nowrite_stall: got %0d exp 0", s_stall); else checks_passed++;
      step();
      checks_total++;
      if ({reg_we, vreg_we, q_count, reg_addr, vreg_addr} !== {1'b0, 4'b0, 3'd0, 5'd8, 5'd9})
         $display("FAIL nowrite: got we=%0d vwe=%b q=%0d addr=%0d vaddr=%0d exp 0/0000/0/8/9",
                  reg_we, vreg_we, q_count, reg_addr, vreg_addr);
      else checks_passed++;
      idle();
   endtask

   task automatic test_reset_midstream();
      set_s(1, 1, 0, 5'd1, 0, 36'h1, 0, 0);
      set_v(1, 1, 0, 5'd2, 0, 36'h2, 0, 0);
      step();
      set_v(1, 1, 0, 5'd3, 0, 36'h3, 0, 0);
      step();
      checks_total++;
      if (q_count !== 3'd2) $display("FAIL mid_prefill: got q=%0d exp 2", q_count); else checks_passed++;
      #2;
      rst = 1'b1;
      #1;
      checks_total++;
      if ({reg_we, reg_addr, reg_data, vreg_we, q_count, s_stall} !== '0)
         $display("FAIL mid_reset: got we=%0d addr=%0d q=%0d stall=%0d exp all 0",
                  reg_we, reg_addr, q_count, s_stall);
      else checks_passed++;
      idle();
      step();
      rst = 1'b0;
      set_s(1, 1, 0, 5'd4, 0, 36'h44, 0, 0);
      step();
      checks_total++;
      if ({reg_we, reg_addr, reg_data, q_count} !== {1'b1, 5'd4, 36'h44, 3'd0})
         $display("FAIL post_reset: got we=%0d addr=%0d data=%h q=%0d exp 1/4/44/0",
                  reg_we, reg_addr, reg_data, q_count);
      else checks_passed++;
      idle();
      step();
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      test_reset();
      test_scalar_write();
      test_disjoint();
      test_conflict_queue();
      test_sustained();
      test_atomic();
      test_no_write();
      test_reset_midstream();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
